mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide responder serving the EX stage's MULT/MULTU/DIV/DIVU request.
- EX raises a request level with the operands and holds the instruction while its stall_request is high (stall_request = !mult_div_done). This unit computes the 64-bit {HI,LO} value and pulses done with the result.
- Sits beside EX. Its outputs feed EX's mult_div_done and mult_div_result inputs.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  EX holds a mult/div instruction (level)
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- operand_1  in  WIDTH  rs value (multiplicand / dividend)
- operand_2  in  WIDTH  rt value (multiplier / divisor)
- ex_stall  in  1  EX held by a stall other than this unit's
- flush  in  1  pipeline flush (exception/eret); aborts the operation
- done  out  1  result valid this cycle
- result  out  2*WIDTH  {HI,LO}: product, or {remainder, quotient}

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, done=0, result=0, counter=0, internal registers=0. Applies mid-operation too.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start=1, flush=0:
  - Latch |operand_1|, |operand_2|, negate flags and op. Absolute value is taken only for signed ops; the operand MSB is the sign bit.
  - Clear the counter and accumulator.
  - Go to MUL or DIV.
  - Exception: DIV/DIVU with operand_2==0 goes straight to DONE with result={operand_1, all-ones}.
- MUL: radix-2 shift-add, one multiplier bit per cycle; counter increments. After WIDTH iterations go to DONE; the product is negated if the signed op has sign1^sign2.
- DIV: restoring division, one quotient bit per cycle.
  - After WIDTH iterations go to DONE.
  - Signed quotient is negated if sign1^sign2.
  - Signed remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000 and remainder 0 (wrap, no trap).
- DONE: done=1, result valid.
  - ex_stall=0: next state IDLE.
  - ex_stall=1: stay in DONE with done held high, so a held EX instruction is not recomputed.
- Latency: start first seen in cycle 0 gives done=1 in cycle WIDTH+1 (33). Divide-by-zero gives done in cycle 1.
- Back-to-back: DONE→IDLE, then a new start is accepted the next cycle, so there is one idle cycle between operations.
- result is registered and updated only on entry to DONE. It holds its value through IDLE until the next DONE.
- done is 0 in every state except DONE.
- flush=1 in any state: next state IDLE, done=0, result unchanged. Flush has priority over start and over completion in the same cycle.
- op, operand_1 and operand_2 are sampled only in IDLE. Later changes are ignored until the next IDLE.
- start=0 during MUL/DIV does not abort; only flush or rst aborts.

Decomposition:
- Shared package/header holds:
  - op encodings (MD_OP_MULT=2'b00, MD_OP_MULTU=2'b01, MD_OP_DIV=2'b10, MD_OP_DIVU=2'b11)
  - state encodings
  - the MULT_DIV_BUS width (2*WIDTH)
- EX-side decode of funct→op uses these constants.
- Sign pre/post-processing (abs and conditional negate) goes in one natural sub-module, md_sign_fix, instantiated once for operands and once for results. Datapath and FSM stay in mult_div_unit.

Test Plan:
- MULT, operand_1=0xFFFFFFFD (−3), operand_2=7 → done=1 exactly in cycle 33, result=0xFFFFFFFF_FFFFFFEB; done=0 in cycle 34.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → result=0xFFFFFFFE_00000001.
- Signed division:
  - DIV 0xFFFFFFF9 (−7) / 2 → result={0xFFFFFFFF, 0xFFFFFFFD}.
  - DIV 0x80000000 / 0xFFFFFFFF → result={0x00000000, 0x80000000}.
- DIVU 100 / 0 → done in cycle 1, result={0x00000064, 0xFFFFFFFF}.
- Flush:
  - Start DIVU 100/7, assert flush in cycle 10 → IDLE in cycle 11, done never asserted, result keeps its prior value.
  - Restart DIVU 100/7 → result={0x00000002, 0x0000000E} at cycle 33 after the restart.
- DONE hold and back-to-back:
  - ex_stall=1 during DONE for 3 cycles → done stays 1 and result stable, no recompute.
  - Release ex_stall, then a back-to-back MULTU 3×5 → accepted after one IDLE cycle, result=0x00000000_0000000F.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the iterative multiply/divide unit: op and state encodings, bus width.
package mult_div_unit_pkg;

  localparam int MD_WIDTH       = 32;
  localparam int MULT_DIV_BUS_W = 2 * MD_WIDTH;

  typedef enum logic [1:0] {
    MD_OP_MULT  = 2'b00,
    MD_OP_MULTU = 2'b01,
    MD_OP_DIV   = 2'b10,
    MD_OP_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10,
    MD_DONE = 2'b11
  } md_state_t;

  // op[1] selects divide, op[0] selects the unsigned flavour
  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the EX stage (master) and the mult/div unit (slave).
interface mult_div_unit_if #(
  parameter int WIDTH = mult_div_unit_pkg::MD_WIDTH
) ();

  logic                 start;
  logic [1:0]           op;
  logic [WIDTH-1:0]     operand_1;
  logic [WIDTH-1:0]     operand_2;
  logic                 ex_stall;
  logic                 flush;
  logic                 done;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, op, operand_1, operand_2, ex_stall, flush,
    input  done, result
  );

  modport slave (
    input  start, op, operand_1, operand_2, ex_stall, flush,
    output done, result
  );

endinterface

// File: rtl/mult_div_unit_md_sign_fix.sv
// Conditional two's-complement negate of a {hi,lo} pair, either as two independent
// words or (joint=1) as one double-width value.
module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic             neg_hi,
  input  logic             neg_lo,
  input  logic             joint,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [2*WIDTH-1:0] pair_neg;

  assign pair_neg = -{hi_in, lo_in};

  // In joint mode neg_lo controls the whole double-width value
  always_comb begin
    hi_out = hi_in;
    lo_out = lo_in;
    if (joint) begin
      if (neg_lo) begin
        {hi_out, lo_out} = pair_neg;
      end
    end else begin
      if (neg_hi) hi_out = -hi_in;
      if (neg_lo) lo_out = -lo_in;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide responder for the EX stage: one result bit per cycle,
// result registered on entry to DONE and held until the next completion.
//
//   state | meaning
//   IDLE  | waiting for start; operands/op sampled here
//   MUL   | shift-add multiply, WIDTH iterations
//   DIV   | restoring divide, WIDTH iterations
//   DONE  | done=1; held while ex_stall so the held instruction is not recomputed
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic              clk,
  input logic              rst,
  mult_div_unit_if.slave   md
);

  md_state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc_hi, acc_lo, b_reg;
  logic               is_mul, neg_hi_q, neg_lo_q;
  logic [2*WIDTH-1:0] result_q;

  logic [WIDTH-1:0]   abs_1, abs_2;
  logic [WIDTH-1:0]   addend, iter_hi, iter_lo, fix_hi, fix_lo;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic               sgn, div_zero, last_iter;

  assign sgn       = md_is_signed(md.op);
  assign div_zero  = md_is_div(md.op) && (md.operand_2 == '0);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  md_sign_fix #(.WIDTH(WIDTH)) u_opnd_fix (
    .hi_in  (md.operand_1),
    .lo_in  (md.operand_2),
    .neg_hi (sgn & md.operand_1[WIDTH-1]),
    .neg_lo (sgn & md.operand_2[WIDTH-1]),
    .joint  (1'b0),
    .hi_out (abs_1),
    .lo_out (abs_2)
  );

  // acc_hi holds the running product high word / partial remainder;
  // acc_lo holds the multiplier being shifted out / dividend shifting into the quotient
  always_comb begin
    addend    = acc_lo[0] ? b_reg : {WIDTH{1'b0}};
    mul_sum   = {1'b0, acc_hi} + {1'b0, addend};
    div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, b_reg};
    iter_hi   = acc_hi;
    iter_lo   = acc_lo;
    if (state == MD_MUL) begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else if (state == MD_DIV) begin
      if (!div_trial[WIDTH]) begin
        iter_hi = div_trial[WIDTH-1:0];
      end else begin
        iter_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
      end
      iter_lo = {acc_lo[WIDTH-2:0], ~div_trial[WIDTH]};
    end
  end

  md_sign_fix #(.WIDTH(WIDTH)) u_result_fix (
    .hi_in  (iter_hi),
    .lo_in  (iter_lo),
    .neg_hi (neg_hi_q),
    .neg_lo (neg_lo_q),
    .joint  (is_mul),
    .hi_out (fix_hi),
    .lo_out (fix_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (md.flush) begin
      state_nxt = MD_IDLE;
    end else begin
      case (state)
        MD_IDLE: begin
          if (md.start) begin
            if (div_zero)                state_nxt = MD_DONE;
            else if (md_is_div(md.op))   state_nxt = MD_DIV;
            else                         state_nxt = MD_MUL;
          end
        end
        MD_MUL, MD_DIV: if (last_iter) state_nxt = MD_DONE;
        MD_DONE:        if (!md.ex_stall) state_nxt = MD_IDLE;
        default:        state_nxt = MD_IDLE;
      endcase
    end
  end

  always_comb begin
    md.done   = (state == MD_DONE);
    md.result = result_q;
  end

  // Flush blocks every datapath update, including a completion in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      b_reg    <= '0;
      is_mul   <= 1'b0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
      result_q <= '0;
    end else if (!md.flush) begin
      case (state)
        MD_IDLE: begin
          if (md.start) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= md_is_div(md.op) ? abs_1 : abs_2;
            b_reg    <= md_is_div(md.op) ? abs_2 : abs_1;
            is_mul   <= ~md_is_div(md.op);
            neg_hi_q <= sgn & md.operand_1[WIDTH-1];
            neg_lo_q <= sgn & (md.operand_1[WIDTH-1] ^ md.operand_2[WIDTH-1]);
            if (div_zero) result_q <= {md.operand_1, {WIDTH{1'b1}}};
          end
        end
        MD_MUL, MD_DIV: begin
          cnt    <= cnt + CNT_W'(1);
          acc_hi <= iter_hi;
          acc_lo <= iter_lo;
          if (last_iter) result_q <= {fix_hi, fix_lo};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, signed/unsigned results, divide-by-zero,
// flush abort, DONE hold under ex_stall, back-to-back issue and mid-operation reset.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   lat;
  int   done_seen;
  logic [63:0] held;

  mult_div_unit_if #(.WIDTH(32)) md_bus ();

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .md  (md_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue an op in the current cycle (cycle 0) and hold start until done or timeout
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    md_bus.op        = op;
    md_bus.operand_1 = a;
    md_bus.operand_2 = b;
    md_bus.start     = 1'b1;
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!md_bus.done && cycles < 60);
    md_bus.start = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    md_bus.start     = 1'b0;
    md_bus.op        = 2'b00;
    md_bus.operand_1 = '0;
    md_bus.operand_2 = '0;
    md_bus.ex_stall  = 1'b0;
    md_bus.flush     = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset_done", 64'(md_bus.done), 64'd0);
    check("reset_result", md_bus.result, 64'd0);

    run_op(MD_OP_MULT, 32'hFFFF_FFFD, 32'd7, lat);
    check("mult_latency", 64'(lat), 64'd33);
    check("mult_result", md_bus.result, 64'hFFFF_FFFF_FFFF_FFEB);
    step();
    check("mult_done_drop", 64'(md_bus.done), 64'd0);

    run_op(MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("multu_latency", 64'(lat), 64'd33);
    check("multu_result", md_bus.result, 64'hFFFF_FFFE_0000_0001);
    step();

    run_op(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, lat);
    check("div_neg_latency", 64'(lat), 64'd33);
    check("div_neg_result", md_bus.result, 64'hFFFF_FFFF_FFFF_FFFD);
    step();

    run_op(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("div_ovf_latency", 64'(lat), 64'd33);
    check("div_ovf_result", md_bus.result, 64'h0000_0000_8000_0000);
    step();

    run_op(MD_OP_DIVU, 32'd100, 32'd0, lat);
    check("divz_latency", 64'(lat), 64'd1);
    check("divz_result", md_bus.result, 64'h0000_0064_FFFF_FFFF);
    step();
    check("divz_idle_done", 64'(md_bus.done), 64'd0);

    // Flush in cycle 10 of a DIVU: unit idles, never completes, result untouched
    md_bus.op        = MD_OP_DIVU;
    md_bus.operand_1 = 32'd100;
    md_bus.operand_2 = 32'd7;
    md_bus.start     = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (md_bus.done) done_seen++;
    end
    md_bus.flush = 1'b1;
    md_bus.start = 1'b0;
    step();
    md_bus.flush = 1'b0;
    check("flush_idle", 64'(dut.state), 64'(MD_IDLE));
    for (int i = 0; i < 40; i++) begin
      if (md_bus.done) done_seen++;
      step();
    end
    check("flush_no_done", 64'(done_seen), 64'd0);
    check("flush_result_kept", md_bus.result, 64'h0000_0064_FFFF_FFFF);

    run_op(MD_OP_DIVU, 32'd100, 32'd7, lat);
    check("restart_latency", 64'(lat), 64'd33);
    check("restart_result", md_bus.result, 64'h0000_0002_0000_000E);

    // Hold DONE for three cycles under an external stall
    md_bus.ex_stall = 1'b1;
    held = md_bus.result;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_done", 64'(md_bus.done), 64'd1);
      check("hold_result", md_bus.result, 64'h0000_0002_0000_000E);
    end
    md_bus.ex_stall = 1'b0;
    step();
    check("b2b_idle_done", 64'(md_bus.done), 64'd0);

    // Back-to-back MULTU; start and operands change after acceptance and must be ignored
    md_bus.op        = MD_OP_MULTU;
    md_bus.operand_1 = 32'd3;
    md_bus.operand_2 = 32'd5;
    md_bus.start     = 1'b1;
    step();
    lat = 1;
    md_bus.start     = 1'b0;
    md_bus.op        = MD_OP_DIV;
    md_bus.operand_1 = 32'hFFFF_FFFF;
    md_bus.operand_2 = 32'hFFFF_FFFF;
    while (!md_bus.done && lat < 60) begin
      step();
      lat++;
    end
    check("b2b_latency", 64'(lat), 64'd33);
    check("b2b_result", md_bus.result, 64'h0000_0000_0000_000F);
    check("b2b_prev_changed", 64'(held != md_bus.result), 64'd1);
    step();

    // Reset in the middle of a multiply clears everything
    md_bus.op        = MD_OP_MULT;
    md_bus.operand_1 = 32'd9;
    md_bus.operand_2 = 32'd9;
    md_bus.start     = 1'b1;
    repeat (5) step();
    rst          = 1'b1;
    md_bus.start = 1'b0;
    step();
    rst = 1'b0;
    check("midrst_state", 64'(dut.state), 64'(MD_IDLE));
    check("midrst_done", 64'(md_bus.done), 64'd0);
    check("midrst_result", md_bus.result, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
